// File: rtl/rtc_fattime_pack.sv
// rtc_fattime_pack
// Packs the DS1302 BCD calendar registers into a 32-bit FAT timestamp.
//
// A stability filter takes a coherent snapshot of the six calendar fields.
// On a Start_Sig request, a small FSM copies the snapshot into working
// registers. It converts each BCD field to binary, one field per cycle,
// then packs the fields and pulses Done_Sig.
//
// Optional build macro: FATTIME_RANGE_CHECK_EN
//   defined   -> PACK validates fields; invalid input gives Err=1 and 1980-01-01.
//   undefined -> no validation; Err stays 0 and fields are truncated.
module rtc_fattime_pack #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [7:0]  Time_year,
    input  logic [7:0]  Time_month,
    input  logic [7:0]  Time_date,
    input  logic [7:0]  Time_hour,
    input  logic [7:0]  Time_munite,
    input  logic [7:0]  Time_second,
    input  logic        Start_Sig,
    output logic        Done_Sig,
    output logic [31:0] FatTime,
    output logic        Err,
    output logic        Snap_Valid
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CONV    = 3'd1,
        S_PACK    = 3'd2,
        S_DONE    = 3'd3,
        S_WAITLOW = 3'd4
    } state_t;

    localparam logic [7:0]  LP_STABLE    = 8'(STABLE_CYCLES);
    localparam logic [7:0]  LP_STABLE_M1 = 8'(STABLE_CYCLES - 1);
    localparam logic [31:0] LP_FAT_EPOCH = 32'h0021_0000;

    // BCD byte to binary: tens*10 + ones, computed as (tens<<3)+(tens<<1)+ones.
    // Illegal nibbles still produce a value (at most 165), so 8 bits suffice.
    function automatic logic [7:0] bcd2bin(input logic [7:0] bcd);
        logic [7:0] tens;
        tens = {4'h0, bcd[7:4]};
        return (tens << 3) + (tens << 1) + {4'h0, bcd[3:0]};
    endfunction

    // Snapshot stage
    logic [47:0] w_live;
    logic [47:0] r_copy;
    logic [47:0] r_snap;
    logic [7:0]  r_cnt;
    logic        r_snap_valid;

    // Conversion and packing
    state_t      r_state;
    logic [2:0]  r_idx;
    logic [47:0] r_work;
    logic [7:0]  r_bin_sec;
    logic [7:0]  r_bin_min;
    logic [7:0]  r_bin_hour;
    logic [7:0]  r_bin_date;
    logic [7:0]  r_bin_mon;
    logic [7:0]  r_bin_year;
    logic [7:0]  w_cur_bin;
    logic [7:0]  w_year_p;
    logic [31:0] w_packed;
    logic        w_err;
    logic [31:0] r_fattime;
    logic        r_err;
    logic        r_done;
    logic        w_unused;

    assign w_live = {Time_year, Time_month, Time_date, Time_hour, Time_munite, Time_second};

    // Stability filter: a snapshot is taken only after the inputs match the copy for STABLE_CYCLES edges
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_copy       <= 48'd0;
            r_snap       <= 48'd0;
            r_cnt        <= 8'd0;
            r_snap_valid <= 1'b0;
        end else if (w_live != r_copy) begin
            r_copy <= w_live;
            r_cnt  <= 8'd0;
        end else if (r_cnt != LP_STABLE) begin
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt == LP_STABLE_M1) begin
                r_snap       <= r_copy;
                r_snap_valid <= 1'b1;
            end
        end
    end

    // Selects the masked BCD field addressed by idx and converts it to binary
    always_comb begin
        w_cur_bin = 8'd0;
        case (r_idx)
            3'd0:    w_cur_bin = bcd2bin({1'b0, r_work[6:0]});
            3'd1:    w_cur_bin = bcd2bin({1'b0, r_work[14:8]});
            3'd2:    w_cur_bin = bcd2bin({2'b00, r_work[21:16]});
            3'd3:    w_cur_bin = bcd2bin({2'b00, r_work[29:24]});
            3'd4:    w_cur_bin = bcd2bin({3'b000, r_work[36:32]});
            3'd5:    w_cur_bin = bcd2bin(r_work[47:40]);
            default: w_cur_bin = 8'd0;
        endcase
    end

    // FAT layout: year-1980 | month | date | hour | minute | second/2
    always_comb begin
        w_year_p = r_bin_year + 8'd20;
        w_packed = {w_year_p[6:0], r_bin_mon[3:0], r_bin_date[4:0],
                    r_bin_hour[4:0], r_bin_min[5:0], r_bin_sec[5:1]};
    end

`ifdef FATTIME_RANGE_CHECK_EN
    // Field validation: illegal BCD nibbles, out-of-range values, or 12-hour mode
    always_comb begin
        w_err = 1'b0;
        if ((r_work[3:0]   > 4'd9) || (r_work[11:8]  > 4'd9) ||
            (r_work[19:16] > 4'd9) || (r_work[27:24] > 4'd9) ||
            (r_work[35:32] > 4'd9) || (r_work[43:40] > 4'd9) ||
            (r_work[47:44] > 4'd9)) begin
            w_err = 1'b1;
        end else if ((r_bin_mon < 8'd1) || (r_bin_mon > 8'd12) ||
                     (r_bin_date < 8'd1) || (r_bin_date > 8'd31) ||
                     (r_bin_hour > 8'd23) || r_work[23] ||
                     (r_bin_min > 8'd59) || (r_bin_sec > 8'd59)) begin
            w_err = 1'b1;
        end else begin
            w_err = 1'b0;
        end
    end
`else
    assign w_err = 1'b0;
`endif

    // Bits outside the packed field widths are intentionally dropped
    assign w_unused = ^{r_work, r_bin_sec, r_bin_min, r_bin_hour,
                        r_bin_date, r_bin_mon, w_year_p};

    // Request FSM: load, convert one field per cycle, pack, pulse Done, then wait for Start to drop.
    // The load edge also converts seconds, so CONV covers the remaining five fields (idx 1..5).
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state    <= S_IDLE;
            r_idx      <= 3'd0;
            r_work     <= 48'd0;
            r_bin_sec  <= 8'd0;
            r_bin_min  <= 8'd0;
            r_bin_hour <= 8'd0;
            r_bin_date <= 8'd0;
            r_bin_mon  <= 8'd0;
            r_bin_year <= 8'd0;
            r_fattime  <= 32'd0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (Start_Sig && r_snap_valid) begin
                        r_work    <= r_snap;
                        r_bin_sec <= bcd2bin({1'b0, r_snap[6:0]});
                        r_idx     <= 3'd1;
                        r_state   <= S_CONV;
                    end
                end
                S_CONV: begin
                    case (r_idx)
                        3'd1:    r_bin_min  <= w_cur_bin;
                        3'd2:    r_bin_hour <= w_cur_bin;
                        3'd3:    r_bin_date <= w_cur_bin;
                        3'd4:    r_bin_mon  <= w_cur_bin;
                        3'd5:    r_bin_year <= w_cur_bin;
                        default: r_bin_sec  <= w_cur_bin;
                    endcase
                    if (r_idx == 3'd5) begin
                        r_state <= S_PACK;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                S_PACK: begin
                    r_fattime <= w_err ? LP_FAT_EPOCH : w_packed;
                    r_err     <= w_err;
                    r_done    <= 1'b1;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_WAITLOW;
                end
                S_WAITLOW: begin
                    r_done <= 1'b0;
                    if (!Start_Sig) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Done_Sig   = r_done;
    assign FatTime    = r_fattime;
    assign Err        = r_err;
    assign Snap_Valid = r_snap_valid;

endmodule

// File: tb/tb_rtc_fattime_pack.sv
// Scoreboard bench for rtc_fattime_pack.
// Stimulus pushes the expected {Err, FatTime} into a queue.
// A monitor pops the queue and compares on every Done_Sig pulse.
module tb_rtc_fattime_pack;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic [7:0]  yr, mo, dt, hr, mi, se;
    logic        start;
    logic        Done_Sig;
    logic [31:0] FatTime;
    logic        Err;
    logic        Snap_Valid;

    int n_cmp = 0;
    int n_bad = 0;
    logic [32:0] exp_q[$];

    localparam logic [32:0] EXP_NOM = {1'b0, 32'h58CF_6DAF};
    localparam logic [32:0] EXP_ODD = {1'b0, 32'h58CF_6DBD};
`ifdef FATTIME_RANGE_CHECK_EN
    localparam logic [32:0] EXP_M13 = {1'b1, 32'h0021_0000};
`else
    localparam logic [32:0] EXP_M13 = {1'b0, 32'h59AF_6DAF};
`endif

    rtc_fattime_pack #(.STABLE_CYCLES(4)) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .Time_year   (yr),
        .Time_month  (mo),
        .Time_date   (dt),
        .Time_hour   (hr),
        .Time_munite (mi),
        .Time_second (se),
        .Start_Sig   (start),
        .Done_Sig    (Done_Sig),
        .FatTime     (FatTime),
        .Err         (Err),
        .Snap_Valid  (Snap_Valid)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            @(negedge CLK);
        end
    endtask

    task automatic set_nominal();
        yr = 8'h24; mo = 8'h06; dt = 8'h15; hr = 8'h13; mi = 8'h45; se = 8'h30;
    endtask

    // Raise Start and count edges until Done is observed. Start is left high.
    task automatic run_req(input logic [32:0] exp, input int exp_lat);
        int  n;
        bit  seen;
        exp_q.push_back(exp);
        start = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(posedge CLK);
            n++;
            @(negedge CLK);
            if (Done_Sig) seen = 1'b1;
        end
        check("done_latency", 64'(n), 64'(exp_lat));
    endtask

    // Monitor: every Done pulse must match the oldest queued expectation
    initial begin
        forever begin
            @(negedge CLK);
            if (RSTn && Done_Sig) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got Done with FatTime 0x%0h expected no Done", FatTime);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    check("done_result", 64'({Err, FatTime}), 64'(e));
                end
            end
        end
    end

    initial begin
        int snap_edge;
        int done_edge;
        start = 1'b0;
        set_nominal();
        RSTn = 1'b0;
        step(3);
        check("rst_fattime", 64'(FatTime), 64'd0);
        check("rst_err", 64'(Err), 64'd0);
        check("rst_done", 64'(Done_Sig), 64'd0);
        check("rst_snap_valid", 64'(Snap_Valid), 64'd0);

        // Coherence: second changes every 3 cycles, so no snapshot can form and Start waits
        RSTn = 1'b1;
        start = 1'b1;
        for (int k = 0; k < 9; k++) begin
            se = 8'h31 + 8'(k);
            step(3);
        end
        check("coherence_snap_valid", 64'(Snap_Valid), 64'd0);

        // Inputs settle: snapshot after 5 edges, then load at edge 6 and Done after edge 12
        se = 8'h30;
        exp_q.push_back(EXP_NOM);
        snap_edge = 0;
        done_edge = 0;
        for (int e = 1; e <= 40 && done_edge == 0; e++) begin
            step(1);
            if (Snap_Valid && snap_edge == 0) snap_edge = e;
            if (Done_Sig) done_edge = e;
        end
        check("first_snap_edge", 64'(snap_edge), 64'd5);
        check("held_start_done_edge", 64'(done_edge), 64'd12);

        // Handshake: Start stays high after Done and must not be serviced again
        step(3);
        check("no_redone_done", 64'(Done_Sig), 64'd0);
        check("fattime_held", 64'({Err, FatTime}), 64'(EXP_NOM));
        start = 1'b0;
        step(2);
        run_req(EXP_NOM, 7);
        start = 1'b0;
        step(2);

        // Odd second with the CH flag set: 59 s gives a 29 two-second count
        se = 8'hD9;
        step(8);
        run_req(EXP_ODD, 7);
        check("odd_sec_field", 64'(FatTime[4:0]), 64'd29);
        check("odd_min_field", 64'(FatTime[10:5]), 64'd45);
        start = 1'b0;
        step(2);

        // Month 13
        se = 8'h30;
        mo = 8'h13;
        step(8);
        run_req(EXP_M13, 7);
        start = 1'b0;
        mo = 8'h06;
        step(8);

        // Reset in the middle of conversion: everything clears, and no Done is issued
        start = 1'b1;
        step(3);
        RSTn = 1'b0;
        #1;
        check("midrst_fattime", 64'(FatTime), 64'd0);
        check("midrst_err", 64'(Err), 64'd0);
        check("midrst_done", 64'(Done_Sig), 64'd0);
        check("midrst_snap_valid", 64'(Snap_Valid), 64'd0);
        start = 1'b0;
        step(2);
        RSTn = 1'b1;
        step(8);
        run_req(EXP_NOM, 7);
        start = 1'b0;
        step(4);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
